qr_givens_scheduler: RTL and testbench

- Sequences the shared row-rotation (Givens/CORDIC) engine to triangularise an NROW-row real-valued channel matrix in place; received-vector element travels with each row.
- Sits between the matrix register file and the rotation engine.
- Generates read row pairs and column offsets, waits the engine's fixed pipeline latency, then issues write-back.
- Dependencies are serialised: consecutive rotations within a column share the pivot row.

---
 rtl/qr_givens_scheduler_pkg.sv | 17 +
 rtl/qr_givens_scheduler_pair.sv | 50 +++++
 rtl/qr_givens_scheduler.sv | 132 +++++++++++++
 tb/tb_qr_givens_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/qr_givens_scheduler_pkg.sv
// Shared constants and FSM encoding for the
// Givens QR rotation scheduler.
package qr_givens_scheduler_pkg;

  localparam int QR_NROW = 8;
  // Mirrors the rotation engine's single internal register stage.
  localparam int ROTATION_LAT = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/qr_givens_scheduler_pair.sv
// Nested (c, r) row-pair counter, r running c+1..NROW-1 inside c.
// Advancing past the final pair wraps back to (0, 1).
module qr_pair_counter #(
  parameter  int NROW = 8,
  localparam int IDXW = $clog2(NROW)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            adv,
  input  logic            clr,
  output logic [IDXW-1:0] c,
  output logic [IDXW-1:0] r,
  output logic [IDXW-1:0] c_nxt,
  output logic [IDXW-1:0] r_nxt,
  output logic            last
);

  localparam logic [IDXW-1:0] RMAX = IDXW'(NROW - 1);
  localparam logic [IDXW-1:0] CMAX = IDXW'(NROW - 2);
  localparam logic [IDXW-1:0] ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] TWO  = IDXW'(2);

  assign last = (c == CMAX) && (r == RMAX);

  always_comb begin
    c_nxt = c;
    r_nxt = r + ONE;
    if (last) begin
      c_nxt = '0;
      r_nxt = ONE;
    end else if (r == RMAX) begin
      c_nxt = c + ONE;
      r_nxt = c + TWO;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c <= '0;
      r <= ONE;
    end else if (clr) begin
      c <= '0;
      r <= ONE;
    end else if (adv) begin
      c <= c_nxt;
      r <= r_nxt;
    end
  end

endmodule

// File: rtl/qr_givens_scheduler.sv
// Sequences the shared rotation engine over all (pivot, target)
// row pairs, one serialised rotation at a time.
module qr_givens_scheduler
  import qr_givens_scheduler_pkg::*;
#(
  parameter  int NROW = QR_NROW,
  parameter  int LAT  = ROTATION_LAT,
  localparam int IDXW = $clog2(NROW),
  localparam int CNTW = $clog2(NROW * (NROW - 1) / 2 + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            hold,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [IDXW-1:0] rd_row_a,
  output logic [IDXW-1:0] rd_row_b,
  output logic [IDXW-1:0] rd_col,
  output logic            wr_en,
  output logic [IDXW-1:0] wr_row_a,
  output logic [IDXW-1:0] wr_row_b,
  output logic [IDXW-1:0] wr_col,
  output logic [CNTW-1:0] rot_idx
);

  localparam int WTW = $clog2(LAT + 1);

  if (LAT < 1) begin : g_lat_check
    $error("qr_givens_scheduler: LAT must be >= 1");
  end

  state_t          state, state_n;
  logic            adv, clr, ld_rd, cap;
  logic            last;
  logic [WTW-1:0]  wcnt;
  logic [IDXW-1:0] pc_c, pc_r, pc_c_nxt, pc_r_nxt;

  qr_pair_counter #(.NROW(NROW)) u_pair (
    .clk   (clk),
    .rst   (rst),
    .adv   (adv),
    .clr   (clr),
    .c     (pc_c),
    .r     (pc_r),
    .c_nxt (pc_c_nxt),
    .r_nxt (pc_r_nxt),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    adv     = 1'b0;
    clr     = 1'b0;
    ld_rd   = 1'b0;
    cap     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_ISSUE;
          ld_rd   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          cap     = 1'b1;
          state_n = (LAT == 1) ? S_WRITE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt == WTW'(1)) state_n = S_WRITE;
      end
      S_WRITE: begin
        adv = 1'b1;
        if (last) begin
          state_n = S_DONE;
        end else begin
          state_n = S_ISSUE;
          ld_rd   = 1'b1;
        end
      end
      S_DONE: begin
        clr     = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy  = (state == S_ISSUE) || (state == S_WAIT)
              || (state == S_WRITE);
  assign done  = (state == S_DONE);
  assign rd_en = (state == S_ISSUE) && !hold;
  assign wr_en = (state == S_WRITE);

  // rd_* are loaded one cycle early so ISSUE sees registered indices.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_row_a <= '0;
      rd_row_b <= '0;
      rd_col   <= '0;
      wr_row_a <= '0;
      wr_row_b <= '0;
      wr_col   <= '0;
      wcnt     <= '0;
      rot_idx  <= '0;
    end else begin
      if (ld_rd) begin
        rd_row_a <= adv ? pc_c_nxt : pc_c;
        rd_row_b <= adv ? pc_r_nxt : pc_r;
        rd_col   <= adv ? pc_c_nxt : pc_c;
      end
      if (cap) begin
        wr_row_a <= rd_row_a;
        wr_row_b <= rd_row_b;
        wr_col   <= rd_col;
        wcnt     <= WTW'(LAT - 1);
      end else if (state == S_WAIT) begin
        wcnt <= wcnt - WTW'(1);
      end
      if (adv)      rot_idx <= last ? '0 : rot_idx + CNTW'(1);
      else if (clr) rot_idx <= '0;
    end
  end

endmodule

// File: tb/tb_qr_givens_scheduler.sv
// Bench: cycle table for NROW=8/LAT=1, per-instance latency
// scoreboards for LAT=1,3,5 and an NROW=2 instance.
module tb_qr_givens_scheduler;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] col;
    int         due;
  } sb_t;

  typedef struct {
    logic       start;
    logic       rd;
    logic       wr;
    logic       dn;
    logic [2:0] a;
    logic [2:0] b;
    logic [4:0] rot;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic hold = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int N  = (g == 3) ? 2 : 8;
    localparam int L  = (g == 3) ? 1 : 2 * g + 1;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N * (N - 1) / 2 + 1);

    logic          busy, done, rd_en, wr_en;
    logic [IW-1:0] rd_row_a, rd_row_b, rd_col;
    logic [IW-1:0] wr_row_a, wr_row_b, wr_col;
    logic [CW-1:0] rot_idx;
    sb_t           q[$];
    sb_t           e;

    qr_givens_scheduler #(.NROW(N), .LAT(L)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .hold     (hold),
      .busy     (busy),
      .done     (done),
      .rd_en    (rd_en),
      .rd_row_a (rd_row_a),
      .rd_row_b (rd_row_b),
      .rd_col   (rd_col),
      .wr_en    (wr_en),
      .wr_row_a (wr_row_a),
      .wr_row_b (wr_row_b),
      .wr_col   (wr_col),
      .rot_idx  (rot_idx)
    );

    always @(negedge clk) begin
      if (!rst) begin
        q.delete();
      end else begin
        if (rd_en && wr_en) chk($sformatf("overlap%0d", g), 1, 0);
        if (rd_en)
          q.push_back('{3'(rd_row_a), 3'(rd_row_b), 3'(rd_col), cyc + L});
        if (wr_en) begin
          if (q.size() == 0) begin
            chk($sformatf("sb%0d_empty", g), 1, 0);
          end else begin
            e = q.pop_front();
            chk($sformatf("sb%0d_a", g), 32'(wr_row_a), 32'(e.a));
            chk($sformatf("sb%0d_b", g), 32'(wr_row_b), 32'(e.b));
            chk($sformatf("sb%0d_col", g), 32'(wr_col), 32'(e.col));
            chk($sformatf("sb%0d_lat", g), cyc, e.due);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (n < 1000 && (g_dut[0].busy || g_dut[1].busy ||
                        g_dut[2].busy || g_dut[3].busy)) begin
      @(posedge clk);
      n++;
    end
    if (n == 1000) chk("idle_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  vec_t tab[60];

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int dn;
    logic seen;

    for (int i = 0; i < 60; i++)
      tab[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0};
    tab[0].start = 1'b1;
    k = 0;
    for (int c = 0; c < 7; c++)
      for (int r = c + 1; r < 8; r++) begin
        tab[2*k+1] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'(c), 3'(r), 5'(k)};
        tab[2*k+2] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'(c), 3'(r), 5'(k)};
        k++;
      end
    tab[57].dn = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Phase 1: nominal run, cycle-exact table for LAT=1.
    for (int i = 0; i < 60; i++) begin
      start = tab[i].start;
      @(negedge clk);
      if (i == 0)
        chk("reset_state",
            {g_dut[0].busy, g_dut[0].done, g_dut[0].rd_en,
             g_dut[0].wr_en, g_dut[0].rd_row_a, g_dut[0].rd_row_b,
             g_dut[0].rd_col, g_dut[0].wr_row_a, g_dut[0].wr_row_b,
             g_dut[0].wr_col, g_dut[0].rot_idx}, 0);
      chk($sformatf("rd_en@%0d", i), 32'(g_dut[0].rd_en), 32'(tab[i].rd));
      chk($sformatf("wr_en@%0d", i), 32'(g_dut[0].wr_en), 32'(tab[i].wr));
      chk($sformatf("done@%0d", i), 32'(g_dut[0].done), 32'(tab[i].dn));
      chk($sformatf("busy@%0d", i), 32'(g_dut[0].busy),
          32'(i >= 1 && i <= 56));
      if (tab[i].rd)
        chk($sformatf("rd_idx@%0d", i),
            {g_dut[0].rd_row_a, g_dut[0].rd_row_b,
             g_dut[0].rd_col, g_dut[0].rot_idx},
            {tab[i].a, tab[i].b, tab[i].a, tab[i].rot});
      if (tab[i].wr)
        chk($sformatf("wr_idx@%0d", i),
            {g_dut[0].wr_row_a, g_dut[0].wr_row_b,
             g_dut[0].wr_col, g_dut[0].rot_idx},
            {tab[i].a, tab[i].b, tab[i].a, tab[i].rot});
      if (i < 6) begin
        chk($sformatf("n2_rd@%0d", i), 32'(g_dut[3].rd_en), 32'(i == 1));
        chk($sformatf("n2_wr@%0d", i), 32'(g_dut[3].wr_en), 32'(i == 2));
        chk($sformatf("n2_done@%0d", i), 32'(g_dut[3].done), 32'(i == 3));
      end
      @(posedge clk);
      #1;
    end
    wait_idle();

    // Phase 2: hold in cycles 3-6, stray start pulses at 10 and 61.
    dn = 0;
    for (int i = 0; i < 65; i++) begin
      start = (i == 0) || (i == 10) || (i == 61);
      hold  = (i >= 3) && (i <= 6);
      @(negedge clk);
      if (g_dut[0].done) dn++;
      if (i >= 3 && i <= 6)
        chk($sformatf("hold_rd@%0d", i), 32'(g_dut[0].rd_en), 0);
      if (i == 7)
        chk("hold_resume",
            {g_dut[0].rd_en, g_dut[0].rd_row_a,
             g_dut[0].rd_row_b, g_dut[0].rot_idx},
            {1'b1, 3'd0, 3'd2, 5'd1});
      if (i == 4) chk("lat3_wr_in_hold", 32'(g_dut[1].wr_en), 1);
      if (i == 61) chk("hold_done", 32'(g_dut[0].done), 1);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    hold  = 1'b0;
    chk("single_done", dn, 1);
    chk("idle_after_done", 32'(g_dut[0].busy), 0);
    wait_idle();

    // Phase 3: restart from (0,1), then async reset during WRITE.
    for (int i = 0; i < 20; i++) begin
      start = (i == 0);
      @(negedge clk);
      if (i == 1)
        chk("restart",
            {g_dut[0].rd_en, g_dut[0].rd_row_a,
             g_dut[0].rd_row_b, g_dut[0].rot_idx},
            {1'b1, 3'd0, 3'd1, 5'd0});
      @(posedge clk);
      #1;
    end
    chk("write_before_rst", 32'(g_dut[0].wr_en), 1);
    rst = 1'b0;
    #1;
    chk("async_rst_lat1",
        {g_dut[0].busy, g_dut[0].done, g_dut[0].rd_en,
         g_dut[0].wr_en, g_dut[0].rd_row_a, g_dut[0].rd_row_b,
         g_dut[0].rd_col, g_dut[0].wr_row_a, g_dut[0].wr_row_b,
         g_dut[0].wr_col, g_dut[0].rot_idx}, 0);
    chk("async_rst_lat3",
        {g_dut[1].busy, g_dut[1].rd_en, g_dut[1].wr_en,
         g_dut[1].wr_row_a, g_dut[1].wr_row_b, g_dut[1].rot_idx}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (g_dut[0].wr_en || g_dut[1].wr_en || g_dut[2].wr_en ||
          g_dut[0].busy)
        seen = 1'b1;
    end
    chk("no_wr_after_rst", 32'(seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
